// File: rtl/freq_counter_multi.sv
// freq_counter_multi: measures high time, low time and period (in CLK cycles)
// of NUM_CH asynchronous square-wave inputs, with per-channel synchronisers,
// saturating counters, overflow flags and a stale-input timeout.
// Optional block averaging over 2^AVG_LOG2 measurements: define FREQ_COUNTER_AVG_EN.
//
// Channel FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no measurement in progress, counters held at 0, waiting for rise
//   ST_HIGH | input high, hi_cnt counting
//   ST_LOW  | input low, lo_cnt counting; next rise completes a measurement
module freq_counter_multi #(
  parameter int NUM_CH         = 4,
  parameter int COUNT_WIDTH    = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int AVG_LOG2       = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_CH-1:0]             FREQ_IN,
  output logic [NUM_CH*COUNT_WIDTH-1:0] TIME_HIGH,
  output logic [NUM_CH*COUNT_WIDTH-1:0] TIME_LOW,
  output logic [NUM_CH*COUNT_WIDTH-1:0] PERIOD,
  output logic [NUM_CH-1:0]             VALID,
  output logic [NUM_CH-1:0]             OVF,
  output logic [NUM_CH-1:0]             STALE
);

  // A single-flop synchroniser is never safe, so fewer than two stages is promoted to two.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = COUNT_WIDTH;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_ONE   = IW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SS-1:0]  sync_q;
    logic           s_prev_q;
    logic           rise, fall, timeout;
    state_t         state_q, state_d;
    logic           meas_done;
    logic [CW-1:0]  hi_cnt_q, lo_cnt_q, hi_shadow_q;
    logic           meas_ovf_q;
    logic [IW-1:0]  idle_cnt_q;
    logic [CW:0]    sum_full;
    logic [CW-1:0]  per_sat;
    logic           m_ovf;
    logic [CW-1:0]  th_q, tl_q, per_q;
    logic           valid_q, ovf_q, stale_q;

    assign rise    = sync_q[SS-1] & ~s_prev_q;
    assign fall    = ~sync_q[SS-1] & s_prev_q;
    // An edge always beats the timeout in the same cycle.
    assign timeout = ~rise & ~fall & (idle_cnt_q == IDLE_LAST);

    // Measurement of the completed period, valid when meas_done is high.
    assign sum_full = {1'b0, hi_shadow_q} + {1'b0, lo_cnt_q};
    assign per_sat  = sum_full[CW] ? CNT_MAX : sum_full[CW-1:0];
    assign m_ovf    = meas_ovf_q | sum_full[CW];

    // Input synchroniser and edge-detect history.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        sync_q   <= '0;
        s_prev_q <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SS-2:0], FREQ_IN[i]};
        s_prev_q <= sync_q[SS-1];
      end
    end

    // Idle counter: cleared on any edge, saturates at the limit so it fires once.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        idle_cnt_q <= '0;
      end else if (rise || fall) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IDLE_LIMIT) begin
        idle_cnt_q <= idle_cnt_q + IDLE_ONE;
      end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
    end

    // FSM next state; meas_done marks the rise that closes a full period.
    always_comb begin
      state_d   = state_q;
      meas_done = 1'b0;
      case (state_q)
        ST_IDLE: if (rise) state_d = ST_HIGH;
        ST_HIGH: if (fall) state_d = ST_LOW;
        ST_LOW: begin
          if (rise) begin
            state_d   = ST_HIGH;
            meas_done = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (timeout) state_d = ST_IDLE;
    end

    // Saturating high/low counters; meas_ovf_q remembers any blocked increment.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        hi_cnt_q    <= '0;
        lo_cnt_q    <= '0;
        hi_shadow_q <= '0;
        meas_ovf_q  <= 1'b0;
      end else if (timeout) begin
        hi_cnt_q    <= '0;
        lo_cnt_q    <= '0;
        hi_shadow_q <= '0;
        meas_ovf_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            hi_cnt_q   <= rise ? CNT_ONE : '0;
            lo_cnt_q   <= '0;
            meas_ovf_q <= 1'b0;
          end
          ST_HIGH: begin
            if (fall) begin
              hi_shadow_q <= hi_cnt_q;
              lo_cnt_q    <= CNT_ONE;
            end else if (hi_cnt_q == CNT_MAX) begin
              meas_ovf_q <= 1'b1;
            end else begin
              hi_cnt_q <= hi_cnt_q + CNT_ONE;
            end
          end
          ST_LOW: begin
            if (rise) begin
              hi_cnt_q   <= CNT_ONE;
              meas_ovf_q <= 1'b0;
            end else if (lo_cnt_q == CNT_MAX) begin
              meas_ovf_q <= 1'b1;
            end else begin
              lo_cnt_q <= lo_cnt_q + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end

`ifdef FREQ_COUNTER_AVG_EN
    localparam int AW = CW + AVG_LOG2;
    localparam int WW = AVG_LOG2 + 1;
    localparam logic [WW-1:0] WIN_LAST = WW'((1 << AVG_LOG2) - 1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);

    logic [AW-1:0] acc_hi_q, acc_lo_q, acc_per_q;
    logic [AW-1:0] nx_hi, nx_lo, nx_per;
    logic [WW-1:0] win_q;
    logic          acc_ovf_q;

    assign nx_hi  = acc_hi_q  + AW'(hi_shadow_q);
    assign nx_lo  = acc_lo_q  + AW'(lo_cnt_q);
    assign nx_per = acc_per_q + AW'(per_sat);

    // Window accumulation; one result per 2^AVG_LOG2 measurements, timeout drops the window.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        acc_hi_q  <= '0;
        acc_lo_q  <= '0;
        acc_per_q <= '0;
        win_q     <= '0;
        acc_ovf_q <= 1'b0;
        th_q      <= '0;
        tl_q      <= '0;
        per_q     <= '0;
        valid_q   <= 1'b0;
        ovf_q     <= 1'b0;
        stale_q   <= 1'b0;
      end else begin
        valid_q <= 1'b0;
        if (timeout) begin
          acc_hi_q  <= '0;
          acc_lo_q  <= '0;
          acc_per_q <= '0;
          win_q     <= '0;
          acc_ovf_q <= 1'b0;
          th_q      <= '0;
          tl_q      <= '0;
          per_q     <= '0;
          stale_q   <= 1'b1;
        end else if (meas_done) begin
          if (win_q == WIN_LAST) begin
            th_q      <= CW'(nx_hi >> AVG_LOG2);
            tl_q      <= CW'(nx_lo >> AVG_LOG2);
            per_q     <= CW'(nx_per >> AVG_LOG2);
            valid_q   <= 1'b1;
            ovf_q     <= acc_ovf_q | m_ovf;
            stale_q   <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            acc_per_q <= '0;
            win_q     <= '0;
            acc_ovf_q <= 1'b0;
          end else begin
            acc_hi_q  <= nx_hi;
            acc_lo_q  <= nx_lo;
            acc_per_q <= nx_per;
            win_q     <= win_q + WIN_ONE;
            acc_ovf_q <= acc_ovf_q | m_ovf;
          end
        end
      end
    end
`else
    // Result registers: every completed period is reported on its own.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        th_q    <= '0;
        tl_q    <= '0;
        per_q   <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        stale_q <= 1'b0;
      end else begin
        valid_q <= 1'b0;
        if (meas_done) begin
          th_q    <= hi_shadow_q;
          tl_q    <= lo_cnt_q;
          per_q   <= per_sat;
          valid_q <= 1'b1;
          ovf_q   <= m_ovf;
          stale_q <= 1'b0;
        end else if (timeout) begin
          th_q    <= '0;
          tl_q    <= '0;
          per_q   <= '0;
          stale_q <= 1'b1;
        end
      end
    end
`endif

    assign TIME_HIGH[i*CW +: CW] = th_q;
    assign TIME_LOW[i*CW +: CW]  = tl_q;
    assign PERIOD[i*CW +: CW]    = per_q;
    assign VALID[i]              = valid_q;
    assign OVF[i]                = ovf_q;
    assign STALE[i]              = stale_q;
  end

endmodule

// File: tb/tb_freq_counter_multi.sv
// Bench for freq_counter_multi: a 4-channel 32-bit instance (timeout 100) and a
// 1-channel 8-bit instance (timeout 1000). Slots 0..3 are the main channels, slot 4 the narrow one.
module tb_freq_counter_multi;
  localparam int S      = 2;
  localparam int NM     = 4;
  localparam int NSLOT  = 5;
  localparam int T_MAIN = 100;
  localparam int T_SAT  = 1000;
  localparam int A      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NSLOT-1:0]    drv;
  logic [NM*32-1:0]    th_m, tl_m, per_m;
  logic [NM-1:0]       valid_m, ovf_m, stale_m;
  logic [7:0]          th_s, tl_s, per_s;
  logic [0:0]          valid_s, ovf_s, stale_s;

  freq_counter_multi #(.NUM_CH(NM), .COUNT_WIDTH(32), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T_MAIN)) u_main (
    .CLK(clk), .RST_N(rst_n), .FREQ_IN(drv[3:0]),
    .TIME_HIGH(th_m), .TIME_LOW(tl_m), .PERIOD(per_m),
    .VALID(valid_m), .OVF(ovf_m), .STALE(stale_m));

  freq_counter_multi #(.NUM_CH(1), .COUNT_WIDTH(8), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T_SAT)) u_sat (
    .CLK(clk), .RST_N(rst_n), .FREQ_IN(drv[4:4]),
    .TIME_HIGH(th_s), .TIME_LOW(tl_s), .PERIOD(per_s),
    .VALID(valid_s), .OVF(ovf_s), .STALE(stale_s));

  // ---------------- behavioural model ----------------
  // Works on edge timestamps: an input edge sampled at cycle t takes effect at cycle t+S.
  longint     cyc;
  logic [S+1:0] hist [NSLOT];
  longint     m_last [NSLOT], m_rise [NSLOT], m_fall [NSLOT];
  int         m_phase [NSLOT];
  longint     e_th [NSLOT], e_tl [NSLOT], e_per [NSLOT];
  logic       e_valid [NSLOT], e_ovf [NSLOT], e_stale [NSLOT];
  longint     a_hi [NSLOT], a_lo [NSLOT], a_per [NSLOT];
  int         a_n [NSLOT];
  logic       a_ovf [NSLOT];

  function automatic longint slot_max(input int s);
    return (s == 4) ? 64'd255 : 64'd4294967295;
  endfunction

  function automatic longint slot_tmo(input int s);
    return (s == 4) ? longint'(T_SAT) : longint'(T_MAIN);
  endfunction

  task automatic clear_acc(input int s);
    a_hi[s] = 0; a_lo[s] = 0; a_per[s] = 0; a_n[s] = 0; a_ovf[s] = 1'b0;
  endtask

  task automatic report(input int s, input longint h, input longint l);
    longint mx, hs, ls, ps;
    logic   ov;
    mx = slot_max(s);
    hs = (h > mx) ? mx : h;
    ls = (l > mx) ? mx : l;
    ps = (hs + ls > mx) ? mx : hs + ls;
    ov = (h > mx) || (l > mx) || (hs + ls > mx);
`ifdef FREQ_COUNTER_AVG_EN
    a_hi[s] += hs; a_lo[s] += ls; a_per[s] += ps; a_n[s]++; a_ovf[s] |= ov;
    if (a_n[s] == (1 << A)) begin
      e_th[s] = a_hi[s] >> A; e_tl[s] = a_lo[s] >> A; e_per[s] = a_per[s] >> A;
      e_valid[s] = 1'b1; e_ovf[s] = a_ovf[s]; e_stale[s] = 1'b0;
      clear_acc(s);
    end
`else
    e_th[s] = hs; e_tl[s] = ls; e_per[s] = ps;
    e_valid[s] = 1'b1; e_ovf[s] = ov; e_stale[s] = 1'b0;
`endif
  endtask

  initial begin
    cyc = 0;
    for (int s = 0; s < NSLOT; s++) begin
      hist[s] = '0; m_last[s] = 0; m_rise[s] = 0; m_fall[s] = 0; m_phase[s] = 0;
      e_th[s] = 0; e_tl[s] = 0; e_per[s] = 0;
      e_valid[s] = 1'b0; e_ovf[s] = 1'b0; e_stale[s] = 1'b0;
      clear_acc(s);
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int s = 0; s < NSLOT; s++) begin
        logic rise, fall;
        if (!rst_n) begin
          hist[s] = '0; m_last[s] = cyc; m_phase[s] = 0;
          e_th[s] = 0; e_tl[s] = 0; e_per[s] = 0;
          e_valid[s] = 1'b0; e_ovf[s] = 1'b0; e_stale[s] = 1'b0;
          clear_acc(s);
        end else begin
          hist[s] = {hist[s][S:0], drv[s]};
          rise = hist[s][S] & ~hist[s][S+1];
          fall = ~hist[s][S] & hist[s][S+1];
          e_valid[s] = 1'b0;
          if (rise) begin
            if (m_phase[s] == 2) report(s, m_fall[s] - m_rise[s], cyc - m_fall[s]);
            m_rise[s] = cyc; m_phase[s] = 1; m_last[s] = cyc;
          end else if (fall) begin
            if (m_phase[s] == 1) begin m_fall[s] = cyc; m_phase[s] = 2; end
            m_last[s] = cyc;
          end else if (cyc - m_last[s] == slot_tmo(s)) begin
            e_stale[s] = 1'b1; e_th[s] = 0; e_tl[s] = 0; e_per[s] = 0;
            m_phase[s] = 0;
            clear_acc(s);
          end
        end
      end
    end
  end

  // ---------------- stimulus, generators and checking ----------------
  int n_cmp, n_fail;
  logic        gen_en [NSLOT], gen_hold [NSLOT];
  int          gen_hi [NSLOT], gen_lo [NSLOT], gen_ph [NSLOT];
  logic [63:0] gen_q [NSLOT][$];

  function automatic longint dut_th(input int s);
    return (s < NM) ? longint'(th_m[s*32 +: 32]) : longint'(th_s);
  endfunction
  function automatic longint dut_tl(input int s);
    return (s < NM) ? longint'(tl_m[s*32 +: 32]) : longint'(tl_s);
  endfunction
  function automatic longint dut_per(input int s);
    return (s < NM) ? longint'(per_m[s*32 +: 32]) : longint'(per_s);
  endfunction
  function automatic logic dut_valid(input int s);
    return (s < NM) ? valid_m[s] : valid_s[0];
  endfunction
  function automatic logic dut_ovf(input int s);
    return (s < NM) ? ovf_m[s] : ovf_s[0];
  endfunction
  function automatic logic dut_stale(input int s);
    return (s < NM) ? stale_m[s] : stale_s[0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int s = 0; s < NSLOT; s++) begin
      n_cmp++;
      if (dut_valid(s) !== e_valid[s] || dut_ovf(s) !== e_ovf[s] || dut_stale(s) !== e_stale[s] ||
          dut_th(s) != e_th[s] || dut_tl(s) != e_tl[s] || dut_per(s) != e_per[s]) begin
        n_fail++;
        $display("FAIL cyc%0d slot%0d: got v%0b o%0b s%0b hi%0d lo%0d per%0d, expected v%0b o%0b s%0b hi%0d lo%0d per%0d",
                 cyc, s, dut_valid(s), dut_ovf(s), dut_stale(s), dut_th(s), dut_tl(s), dut_per(s),
                 e_valid[s], e_ovf[s], e_stale[s], e_th[s], e_tl[s], e_per[s]);
      end
    end
  endtask

  task automatic tick();
    logic [63:0] seg;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    for (int s = 0; s < NSLOT; s++) begin
      if (gen_en[s]) begin
        drv[s] = (gen_ph[s] < gen_hi[s]);
        gen_ph[s] = gen_ph[s] + 1;
        if (gen_ph[s] >= gen_hi[s] + gen_lo[s]) begin
          gen_ph[s] = 0;
          if (gen_q[s].size() > 0) begin
            seg = gen_q[s].pop_front();
            gen_hi[s] = int'(seg[63:32]);
            gen_lo[s] = int'(seg[31:0]);
          end
        end
      end else begin
        drv[s] = gen_hold[s];
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start(input int s, input int hi, input int lo);
    gen_hi[s] = hi; gen_lo[s] = lo; gen_ph[s] = 0; gen_en[s] = 1'b1;
    gen_q[s].delete();
  endtask

  task automatic hold(input int s, input logic v);
    gen_en[s] = 1'b0; gen_hold[s] = v;
  endtask

  task automatic wait_valid(input int s, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      if (dut_valid(s)) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_valid slot%0d: got no VALID within %0d cycles, expected one", s, budget);
    end
  endtask

  task automatic check_fields(input string tag, input int s, input longint h, input longint l, input longint p);
    check({tag, "_dut_hi"}, dut_th(s), h);
    check({tag, "_dut_lo"}, dut_tl(s), l);
    check({tag, "_dut_per"}, dut_per(s), p);
    check({tag, "_model_hi"}, e_th[s], h);
    check({tag, "_model_per"}, e_per[s], p);
  endtask

  initial begin
    int vcnt, coinc;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    drv = '0;
    for (int s = 0; s < NSLOT; s++) begin
      gen_en[s] = 1'b0; gen_hold[s] = 1'b0; gen_hi[s] = 1; gen_lo[s] = 1; gen_ph[s] = 0;
    end

    // 1: reset held for 10 cycles while inputs toggle
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < NSLOT; s++) gen_hold[s] = k[0];
      tick();
    end
    check("rst_valid", longint'(valid_m), 0);
    check("rst_th0", dut_th(0), 0);
    check("rst_stale", longint'(stale_m), 0);
    for (int s = 0; s < NSLOT; s++) gen_hold[s] = 1'b0;
    rst_n = 1'b1;

    // 2: channel 0, 3 high / 7 low
    start(0, 3, 7);
    ticks(20);
    vcnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (valid_m[0]) vcnt++;
    end
`ifndef FREQ_COUNTER_AVG_EN
    check("t2_valid_count", vcnt, 5);
`endif
    check_fields("t2", 0, 3, 7, 10);

    // 3: four channels, periods 4/6/8/200 at 50% duty, started together
    start(0, 2, 2); start(1, 3, 3); start(2, 4, 4); start(3, 100, 100);
    coinc = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if ($countones(valid_m) > 1) coinc++;
    end
    check("t3_coincident", (coinc > 0) ? 1 : 0, 1);
    check_fields("t3_ch0", 0, 2, 2, 4);
    check_fields("t3_ch1", 1, 3, 3, 6);
    check_fields("t3_ch2", 2, 4, 4, 8);
    check_fields("t3_ch3", 3, 100, 100, 200);
    check("t3_ch3_not_stale", longint'(stale_m[3]), 0);

    // 4: channel 1 held high until stale, then restarted with a 10-cycle clock
    hold(1, 1'b1);
    ticks(150);
    check("t4_stale_set", longint'(stale_m[1]), 1);
    check_fields("t4_stale", 1, 0, 0, 0);
    start(1, 5, 5);
    ticks(70);
    check("t4_stale_clr", longint'(stale_m[1]), 0);
    check_fields("t4_restart", 1, 5, 5, 10);

    // 5: 8-bit instance, 300 high / 10 low, then 10 / 10
    start(4, 300, 10);
    gen_q[4].push_back({32'd10, 32'd10});
`ifndef FREQ_COUNTER_AVG_EN
    wait_valid(4, 400);
    check_fields("t5_sat", 4, 255, 10, 255);
    check("t5_ovf_set", longint'(ovf_s[0]), 1);
    wait_valid(4, 40);
    check_fields("t5_clean", 4, 10, 10, 20);
    check("t5_ovf_clr", longint'(ovf_s[0]), 0);
`else
    ticks(400);
`endif

    // 6: channel 0 idles to stale, then periods 10,10,12,13 with 5 high each
    hold(0, 1'b0);
    ticks(150);
    check("t6_pre_stale", longint'(stale_m[0]), 1);
    start(0, 5, 5);
    gen_q[0].push_back({32'd5, 32'd5});
    gen_q[0].push_back({32'd5, 32'd7});
    gen_q[0].push_back({32'd5, 32'd8});
    gen_q[0].push_back({32'd5, 32'd5});
    wait_valid(0, 100);
`ifdef FREQ_COUNTER_AVG_EN
    check_fields("t6_avg", 0, 5, 6, 11);
`else
    check_fields("t6_first", 0, 5, 5, 10);
`endif
    check("t6_ovf", longint'(ovf_m[0]), 0);
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
Multi-channel successor to the single-channel frequency counter. Measures high time, low time and period, in CLK cycles, of NUM_CH asynchronous square-wave inputs, for example the outputs of the light-level frequency generators. Adds the following, none of which the single-channel counter has:
- parametrised width and channel count
- input synchronisation
- per-result valid strobes
- saturation and overflow flags
- stale-input timeout
- optional block averaging

Parameters:
NUM_CH, 4, number of independent input channels
COUNT_WIDTH, 32, width of every count/result field
SYNC_STAGES, 2, synchroniser flops per input (minimum 2)
TIMEOUT_CYCLES, 50_000_000, cycles without any edge before a channel is declared stale (1 s at 50 MHz)
AVG_LOG2, 2, log2 of averaging window; used only with FREQ_COUNTER_AVG_EN

Ports:
CLK  input  1  system clock
RST_N  input  1  synchronous active-low reset
FREQ_IN  input  NUM_CH  asynchronous inputs, bit i = channel i
TIME_HIGH  output  NUM_CH*COUNT_WIDTH  high time per channel, field i = [i*COUNT_WIDTH +: COUNT_WIDTH]
TIME_LOW  output  NUM_CH*COUNT_WIDTH  low time per channel, same packing
PERIOD  output  NUM_CH*COUNT_WIDTH  period per channel, same packing
VALID  output  NUM_CH  one-cycle strobe: channel i fields just updated
OVF  output  NUM_CH  a counter in the last reported result saturated
STALE  output  NUM_CH  channel timed out; no edge for TIMEOUT_CYCLES

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled on the rising CLK edge while RST_N=0.
- Reset values: all outputs 0; synchronisers and edge-detect history 0; all counters 0; every channel in state IDLE.
- Per channel:
  - SYNC_STAGES-flop synchroniser, then a 1-flop history register s_prev.
  - rise = s & ~s_prev; fall = ~s & s_prev.
- Channel FSM states: IDLE, HIGH, LOW.
  - IDLE: counters held at 0; on rise -> HIGH with hi_cnt=1.
  - HIGH: hi_cnt+1 each cycle; on fall -> LOW with hi_shadow<=hi_cnt and lo_cnt=1.
  - LOW: lo_cnt+1 each cycle; on rise:
    - TIME_HIGH<=hi_shadow, TIME_LOW<=lo_cnt, PERIOD<=hi_shadow+lo_cnt;
    - VALID=1 for exactly that one cycle;
    - -> HIGH with hi_cnt=1.
  - The first result after IDLE therefore needs a full rise, fall, rise sequence. A fall seen in IDLE is ignored.
- Latency: VALID asserts SYNC_STAGES+1 CLK edges after the first edge that samples the raw input high.
- Arithmetic:
  - hi_cnt, lo_cnt and the PERIOD sum saturate at 2^COUNT_WIDTH-1 and never wrap.
  - Any saturation during a measured period sets OVF for that channel when the result is reported.
  - OVF is updated on every VALID, so a following clean period clears it.
- Timeout:
  - Per-channel idle counter, cleared on rise or fall, incremented otherwise.
  - On reaching TIMEOUT_CYCLES: STALE<=1, TIME_HIGH/TIME_LOW/PERIOD<=0, FSM -> IDLE, no VALID.
  - STALE stays set until the next VALID on that channel.
  - The idle counter saturates; it does not retrigger.
- Simultaneous events: rise and timeout in the same cycle -> the edge wins (idle counter cleared, no STALE).
- Channels are fully independent; simultaneous VALIDs on several channels are legal.
- Reset mid-measurement: synchronous return to reset values on the next edge. No partial result is reported.
- Inputs with a pulse width shorter than one CLK cycle may be missed. No result is guaranteed for them.

Optional Feature:
Macro: FREQ_COUNTER_AVG_EN
- Defined:
  - Per channel, accumulators of width COUNT_WIDTH+AVG_LOG2 sum hi, lo and period over 2^AVG_LOG2 consecutive measurements, plus a window counter.
  - VALID fires once per completed window.
  - Each output = accumulator >> AVG_LOG2, truncated.
  - OVF = OR of per-measurement OVF over the window.
  - Timeout or reset discards the partial window.
- Not defined: every period is reported individually as described above; no accumulator logic is present.

Test Plan:
1. Reset: RST_N=0 for 10 cycles with FREQ_IN toggling -> all outputs 0, no VALID.
2. Channel 0: 10-cycle period, 3 cycles high, phase-locked to CLK -> from the second rise onward TIME_HIGH=3, TIME_LOW=7, PERIOD=10, VALID once per 10 cycles.
3. All 4 channels with periods 4/6/8/200 (50% duty), started simultaneously -> independent correct fields (2/2/4, 3/3/6, 4/4/8, 100/100/200); coincident VALIDs present.
4. Timeout with TIMEOUT_CYCLES=100 and channel 1 held high after a valid result -> STALE[1]=1 and fields 0 at idle count 100; restarting a 10-cycle clock clears STALE on the next VALID.
5. Saturation with COUNT_WIDTH=8 and a 300-cycle high / 10-cycle low input -> TIME_HIGH=255, PERIOD=255, OVF=1; a following 20-cycle period gives OVF=0.
6. Averaging with FREQ_COUNTER_AVG_EN and AVG_LOG2=2, periods 10, 10, 12, 13 (high 5 each) -> a single VALID with PERIOD=11, TIME_HIGH=5, TIME_LOW=6.
